axi_chan_framer: RTL and testbench

//  Framing stage directly downstream of the channelizer output FIFO (axi_fifo_2 m_axis).

---
 rtl/axi_chan_framer_if.sv | 21 ++
 rtl/axi_chan_framer.sv | 197 +++++++++++++++++++
 tb/tb_axi_chan_framer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_chan_framer_if.sv
// -----------------------------------------------------------------------------
// axi_chan_framer_if
//   AXI-Stream channel bundle used on both sides of the framer.
//   Signals: tvalid, tready, tdata[DATA_WIDTH], tuser[BIN_WIDTH], tlast.
//   master : drives tvalid/tdata/tuser/tlast, receives tready
//   slave  : receives tvalid/tdata, drives tready (the framer input side
//            carries no sideband, so tuser/tlast are not part of it)
// -----------------------------------------------------------------------------
interface axi_chan_framer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_WIDTH  = 8
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [BIN_WIDTH-1:0]  tuser;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axi_chan_framer.sv
// -----------------------------------------------------------------------------
// axi_chan_framer
//   Cuts a continuous sample stream into frames of frame_len_m1+1 beats,
//   tagging each beat with its bin index (tuser) and marking the final beat
//   (tlast). Output register plus skid register keep tready registered.
//
//   Ports:
//     clk            single clock
//     async_reset_n  asynchronous active-low reset
//     frame_len_m1   frame length minus 1, sampled on the first beat of a frame
//     flush          early frame completion request (padding build only)
//     s_axis         input stream (slave)
//     m_axis         output stream (master): data, tuser = bin, tlast
//     frame_cnt      frames completed at the input side, wraps
//
//   Build option: define PAD_FLUSH_EN to enable flush padding. Without it the
//   flush input is ignored and the block always runs.
//
//   state | meaning
//   RUN   | accept input beats from s_axis
//   PAD   | input blocked, zero beats generated until the frame's tlast
// -----------------------------------------------------------------------------
module axi_chan_framer #(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_WIDTH  = 8,
    parameter int FCNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  async_reset_n,
    input  logic [BIN_WIDTH-1:0]  frame_len_m1,
    input  logic                  flush,
    axi_chan_framer_if.slave      s_axis,
    axi_chan_framer_if.master     m_axis,
    output logic [FCNT_WIDTH-1:0] frame_cnt
);

`ifdef PAD_FLUSH_EN
    typedef enum logic {ST_RUN, ST_PAD} state_t;
    state_t state_q, state_d;
`endif

    logic                  room_q, room_d;
    logic [BIN_WIDTH-1:0]  bin_q, bin_d;
    logic [BIN_WIDTH-1:0]  len_q, len_d;
    logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

    logic                  or_valid_q, or_valid_d;
    logic [DATA_WIDTH-1:0] or_data_q, or_data_d;
    logic [BIN_WIDTH-1:0]  or_user_q, or_user_d;
    logic                  or_last_q, or_last_d;

    logic                  sr_valid_q, sr_valid_d;
    logic [DATA_WIDTH-1:0] sr_data_q, sr_data_d;
    logic [BIN_WIDTH-1:0]  sr_user_q, sr_user_d;
    logic                  sr_last_q, sr_last_d;

    logic                  accept;
    logic                  gen;
    logic                  beat_vld;
    logic [DATA_WIDTH-1:0] beat_data;
    logic                  beat_last;
    logic [BIN_WIDTH-1:0]  len_eff;

`ifdef PAD_FLUSH_EN
    assign gen            = (state_q == ST_PAD) & room_q;
    assign s_axis.tready  = room_q & (state_q == ST_RUN);
`else
    logic unused_flush;
    assign unused_flush   = flush;
    assign gen            = 1'b0;
    assign s_axis.tready  = room_q;
`endif

    assign accept    = s_axis.tvalid & s_axis.tready;
    assign beat_vld  = accept | gen;
    assign beat_data = gen ? '0 : s_axis.tdata;
    // A new frame takes its length straight from the port on its first beat.
    assign len_eff   = (bin_q == '0) ? frame_len_m1 : len_q;
    assign beat_last = (bin_q == len_eff);

    always_comb begin
        bin_d      = bin_q;
        len_d      = len_q;
        fcnt_d     = fcnt_q;
        or_valid_d = or_valid_q;
        or_data_d  = or_data_q;
        or_user_d  = or_user_q;
        or_last_d  = or_last_q;
        sr_valid_d = sr_valid_q;
        sr_data_d  = sr_data_q;
        sr_user_d  = sr_user_q;
        sr_last_d  = sr_last_q;

        if (beat_vld) begin
            if (bin_q == '0) begin
                len_d = frame_len_m1;
            end
            if (beat_last) begin
                bin_d  = '0;
                fcnt_d = fcnt_q + 1'b1;
            end else begin
                bin_d  = bin_q + 1'b1;
            end
        end

        if (!or_valid_q || m_axis.tready) begin
            if (sr_valid_q) begin
                // Input is blocked while the skid holds a beat, so no new beat
                // competes with the skid drain here.
                or_valid_d = 1'b1;
                or_data_d  = sr_data_q;
                or_user_d  = sr_user_q;
                or_last_d  = sr_last_q;
                sr_valid_d = 1'b0;
            end else if (beat_vld) begin
                or_valid_d = 1'b1;
                or_data_d  = beat_data;
                or_user_d  = bin_q;
                or_last_d  = beat_last;
            end else begin
                or_valid_d = 1'b0;
            end
        end else if (beat_vld) begin
            sr_valid_d = 1'b1;
            sr_data_d  = beat_data;
            sr_user_d  = bin_q;
            sr_last_d  = beat_last;
        end

        room_d = ~sr_valid_d;
    end

`ifdef PAD_FLUSH_EN
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                // A beat closing the frame in the flush cycle leaves nothing to pad.
                if (flush && (bin_q != '0) && (bin_d != '0)) begin
                    state_d = ST_PAD;
                end
            end
            ST_PAD: begin
                if (gen && beat_last) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            room_q     <= 1'b0;
            bin_q      <= '0;
            len_q      <= '0;
            fcnt_q     <= '0;
            or_valid_q <= 1'b0;
            or_data_q  <= '0;
            or_user_q  <= '0;
            or_last_q  <= 1'b0;
            sr_valid_q <= 1'b0;
            sr_data_q  <= '0;
            sr_user_q  <= '0;
            sr_last_q  <= 1'b0;
        end else begin
            room_q     <= room_d;
            bin_q      <= bin_d;
            len_q      <= len_d;
            fcnt_q     <= fcnt_d;
            or_valid_q <= or_valid_d;
            or_data_q  <= or_data_d;
            or_user_q  <= or_user_d;
            or_last_q  <= or_last_d;
            sr_valid_q <= sr_valid_d;
            sr_data_q  <= sr_data_d;
            sr_user_q  <= sr_user_d;
            sr_last_q  <= sr_last_d;
        end
    end

    assign m_axis.tvalid = or_valid_q;
    assign m_axis.tdata  = or_data_q;
    assign m_axis.tuser  = or_user_q;
    assign m_axis.tlast  = or_last_q;
    assign frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_axi_chan_framer.sv
// -----------------------------------------------------------------------------
// tb_axi_chan_framer
//   Directed bench for axi_chan_framer. Inputs are driven 1 time unit after the
//   rising edge, outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_axi_chan_framer;

    logic        clk;
    logic        async_reset_n;
    logic [7:0]  frame_len_m1;
    logic        flush;
    logic [15:0] frame_cnt;

    axi_chan_framer_if #(.DATA_WIDTH(32), .BIN_WIDTH(8)) s_if ();
    axi_chan_framer_if #(.DATA_WIDTH(32), .BIN_WIDTH(8)) m_if ();

    axi_chan_framer #(.DATA_WIDTH(32), .BIN_WIDTH(8), .FCNT_WIDTH(16)) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .frame_len_m1  (frame_len_m1),
        .flush         (flush),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .frame_cnt     (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int latency;
    int low_cnt;

    logic [31:0] obs_data[$];
    logic [7:0]  obs_user[$];
    logic        obs_last[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        async_reset_n = 1'b0;
        s_if.tvalid   = 1'b0;
        s_if.tdata    = '0;
        m_if.tready   = 1'b0;
        flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1 async_reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives n beats base..base+n-1; frame_len_m1 switches from l0 to l1 once
    // chg beats have been accepted. mode: 0 ready, 1 toggling, 2 random.
    task automatic run_stream(input int n, input int base, input logic [7:0] l0,
                              input int chg, input logic [7:0] l1, input int mode);
        int          idx;
        int          cyc;
        int          first_acc;
        int          first_out;
        logic        acc;
        logic        prev_sr_fill;
        logic        prev_hold;
        logic [31:0] hold_data;
        logic [7:0]  hold_user;
        logic        hold_last;
        obs_data.delete();
        obs_user.delete();
        obs_last.delete();
        idx = 0; cyc = 0; first_acc = -1; first_out = -1;
        prev_sr_fill = 1'b0; prev_hold = 1'b0;
        hold_data = '0; hold_user = '0; hold_last = 1'b0;
        frame_len_m1 = (chg == 0) ? l1 : l0;
        s_if.tvalid  = 1'b1;
        s_if.tdata   = base;
        while (obs_data.size() < n && cyc < 4000) begin
            case (mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = (cyc % 2 == 0);
                default: m_if.tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            acc = s_if.tvalid & s_if.tready;
            if (prev_sr_fill) check_val("s_ready_low_sr_full", 64'(s_if.tready), 64'd0);
            if (prev_hold) begin
                check_val("hold_valid", 64'(m_if.tvalid), 64'd1);
                check_val("hold_data",  64'(m_if.tdata),  64'(hold_data));
                check_val("hold_user",  64'(m_if.tuser),  64'(hold_user));
                check_val("hold_last",  64'(m_if.tlast),  64'(hold_last));
            end
            if (acc && first_acc < 0) first_acc = cyc;
            if (m_if.tvalid && m_if.tready) begin
                obs_data.push_back(m_if.tdata);
                obs_user.push_back(m_if.tuser);
                obs_last.push_back(m_if.tlast);
                if (first_out < 0) first_out = cyc;
            end
            prev_sr_fill = acc & m_if.tvalid & ~m_if.tready;
            prev_hold    = m_if.tvalid & ~m_if.tready;
            hold_data    = m_if.tdata;
            hold_user    = m_if.tuser;
            hold_last    = m_if.tlast;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                if (idx == chg) frame_len_m1 = l1;
                if (idx < n) s_if.tdata = base + idx;
                else         s_if.tvalid = 1'b0;
            end
            cyc++;
        end
        s_if.tvalid = 1'b0;
        if (obs_data.size() < n) check_val("stream_timeout", 64'(obs_data.size()), 64'(n));
        latency = first_out - first_acc;
    endtask

    // Reference framing of the stream sent by run_stream; returns tlast count.
    task automatic check_frames(input string tag, input int n, input int base,
                                input logic [7:0] l0, input int chg, input logic [7:0] l1,
                                output int n_last);
        logic [7:0] bin;
        logic [7:0] lq;
        logic       last;
        bin = '0; lq = '0; n_last = 0;
        for (int i = 0; i < n && i < obs_data.size(); i++) begin
            if (bin == 8'd0) lq = (i < chg) ? l0 : l1;
            last = (bin == lq);
            check_val({tag, "_data"}, 64'(obs_data[i]), 64'(base + i));
            check_val({tag, "_user"}, 64'(obs_user[i]), 64'(bin));
            check_val({tag, "_last"}, 64'(obs_last[i]), 64'(last));
            if (last) begin
                bin = '0;
                n_last++;
            end else begin
                bin = bin + 8'd1;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nl;
        int accs;
        frame_len_m1 = 8'd3;
        do_reset();

        // reset state, then ready rises one edge after release
        async_reset_n = 1'b0;
        #2;
        check_val("rst_s_ready",  64'(s_if.tready), 64'd0);
        check_val("rst_m_valid",  64'(m_if.tvalid), 64'd0);
        check_val("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        @(posedge clk);
        #1 async_reset_n = 1'b1;
        @(negedge clk);
        check_val("rst_ready_held", 64'(s_if.tready), 64'd0);
        @(posedge clk);
        #1;
        check_val("ready_after_edge", 64'(s_if.tready), 64'd1);

        // 1: basic framing, len 4, always ready
        do_reset();
        run_stream(12, 1, 8'd3, 1000, 8'd3, 0);
        check_frames("t1", 12, 1, 8'd3, 1000, 8'd3, nl);
        check_val("t1_latency",   64'(latency),   64'd1);
        check_val("t1_frame_cnt", 64'(frame_cnt), 64'd3);
        check_val("t1_nlast",     64'(nl),        64'd3);

        // 2: backpressure, toggling then random
        do_reset();
        run_stream(12, 1, 8'd3, 1000, 8'd3, 1);
        check_frames("t2a", 12, 1, 8'd3, 1000, 8'd3, nl);
        check_val("t2a_frame_cnt", 64'(frame_cnt), 64'd3);
        do_reset();
        run_stream(12, 1, 8'd3, 1000, 8'd3, 2);
        check_frames("t2b", 12, 1, 8'd3, 1000, 8'd3, nl);
        check_val("t2b_frame_cnt", 64'(frame_cnt), 64'd3);

        // 3: length change mid-frame applies from the next frame
        do_reset();
        run_stream(10, 16'h100, 8'd3, 2, 8'd1, 2);
        check_frames("t3", 10, 16'h100, 8'd3, 2, 8'd1, nl);
        check_val("t3_frame_cnt", 64'(frame_cnt), 64'd4);

        // 4: async reset mid-frame (bin=2, output stalled)
        do_reset();
        frame_len_m1 = 8'd3;
        m_if.tready  = 1'b0;
        s_if.tvalid  = 1'b1;
        s_if.tdata   = 32'h55;
        accs = 0;
        for (int c = 0; c < 20 && accs < 2; c++) begin
            @(negedge clk);
            if (s_if.tvalid && s_if.tready) accs++;
            @(posedge clk);
            #1;
            s_if.tdata = 32'h55 + accs;
        end
        s_if.tvalid = 1'b0;
        check_val("t4_pre_valid", 64'(m_if.tvalid), 64'd1);
        #2 async_reset_n = 1'b0;
        #1;
        check_val("t4_m_valid",   64'(m_if.tvalid), 64'd0);
        check_val("t4_m_data",    64'(m_if.tdata),  64'd0);
        check_val("t4_m_user",    64'(m_if.tuser),  64'd0);
        check_val("t4_s_ready",   64'(s_if.tready), 64'd0);
        @(posedge clk);
        #1 async_reset_n = 1'b1;
        @(posedge clk);
        #1;
        run_stream(5, 32'h200, 8'd3, 1000, 8'd3, 0);
        check_frames("t4", 5, 32'h200, 8'd3, 1000, 8'd3, nl);
        check_val("t4_frame_cnt", 64'(frame_cnt), 64'd1);

        // 6: single-beat frames
        do_reset();
        run_stream(6, 32'h300, 8'd0, 1000, 8'd0, 2);
        check_frames("t6", 6, 32'h300, 8'd0, 1000, 8'd0, nl);
        check_val("t6_frame_cnt", 64'(frame_cnt), 64'd6);

        // maximum frame length: bin wraps 255 -> 0
        do_reset();
        run_stream(260, 0, 8'd255, 1000, 8'd255, 0);
        check_frames("tmax", 260, 0, 8'd255, 1000, 8'd255, nl);
        check_val("tmax_frame_cnt", 64'(frame_cnt), 64'd1);

`ifdef PAD_FLUSH_EN
        // 5: flush after 3 beats of an 8-beat frame
        do_reset();
        run_stream(3, 1, 8'd7, 1000, 8'd7, 0);
        check_frames("t5_head", 3, 1, 8'd7, 1000, 8'd7, nl);
        obs_data.delete();
        obs_user.delete();
        obs_last.delete();
        m_if.tready = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        low_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (!s_if.tready) low_cnt++;
            if (m_if.tvalid && m_if.tready) begin
                obs_data.push_back(m_if.tdata);
                obs_user.push_back(m_if.tuser);
                obs_last.push_back(m_if.tlast);
            end
            @(posedge clk);
            #1;
        end
        check_val("t5_pad_beats", 64'(obs_data.size()), 64'd5);
        for (int i = 0; i < 5 && i < obs_data.size(); i++) begin
            check_val("t5_pad_data", 64'(obs_data[i]), 64'd0);
            check_val("t5_pad_user", 64'(obs_user[i]), 64'(3 + i));
            check_val("t5_pad_last", 64'(obs_last[i]), 64'(i == 4));
        end
        check_val("t5_ready_low", 64'(low_cnt),   64'd5);
        check_val("t5_frame_cnt", 64'(frame_cnt), 64'd1);
        check_val("t5_ready_back", 64'(s_if.tready), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
